oled_text_arbiter: RTL and testbench

//  Round-robin arbiter sharing the 4-line OLED text display among NUM_SRC AXI-Stream

---
 rtl/oled_text_arbiter.sv | 151 +++++++++++++++
 tb/tb_oled_text_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_text_arbiter.sv
// oled_text_arbiter
// Round-robin arbiter that shares the 4-line OLED text display among NUM_SRC
// AXI-Stream text producers. A granted 512-bit frame is latched onto the four
// 128-bit line outputs and then held for HOLD_CYCLES so the slow OLED refresh
// can pick it up. A clear pulse blanks the display with spaces.
//
// Valid/ready semantics: a frame moves on a rising edge where both
// s_axis_tvalid[i] and s_axis_tready[i] are high. tready is registered, is
// raised for the granted source only, and only during the single ACCEPT cycle.
// A source that drops tvalid during that cycle transfers nothing.
module oled_text_arbiter #(
   parameter  int NUM_SRC     = 2,
   parameter  int HOLD_CYCLES = 50000000,
   localparam int SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NUM_SRC*512-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]     s_axis_tvalid,
   output logic [NUM_SRC-1:0]     s_axis_tready,
   input  logic                   clear,
   output logic [127:0]           str1,
   output logic [127:0]           str2,
   output logic [127:0]           str3,
   output logic [127:0]           str4,
   output logic                   update,
   output logic [SRC_W-1:0]       src_id,
   output logic                   busy
);

   localparam int           CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [127:0] SPACES = {16{8'h20}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t             state;
   logic [SRC_W-1:0]   grant;
   logic [SRC_W-1:0]   last_grant;
   logic [CNT_W-1:0]   hold_cnt;
   logic               clr_pend;

   logic [SRC_W-1:0]   next_grant;
   logic               found;
   logic [NUM_SRC-1:0] next_oh;
   logic [511:0]       grant_frame;
   logic               handshake;

   // Round-robin search: first requesting source after last_grant, wrapping.
   always_comb begin
      next_grant = last_grant;
      found      = 1'b0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && s_axis_tvalid[i] &&
                (((int'(last_grant) + k) % NUM_SRC) == i)) begin
               next_grant = SRC_W'(i);
               found      = 1'b1;
            end
         end
      end
   end

   // One-hot form of the next grant and the frame of the registered grant.
   always_comb begin
      next_oh     = '0;
      grant_frame = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (next_grant == SRC_W'(i)) begin
            next_oh[i] = 1'b1;
         end
         if (grant == SRC_W'(i)) begin
            grant_frame = s_axis_tdata[i*512 +: 512];
         end
      end
   end

   // tready is nonzero only in ACCEPT, so this is the transfer condition.
   assign handshake = |(s_axis_tvalid & s_axis_tready);
   assign busy      = (state != IDLE);

   // Arbitration FSM plus the registered display outputs and clear handling.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         grant         <= '0;
         last_grant    <= SRC_W'(NUM_SRC - 1);
         hold_cnt      <= '0;
         clr_pend      <= 1'b0;
         s_axis_tready <= '0;
         src_id        <= '0;
         update        <= 1'b0;
         str1          <= SPACES;
         str2          <= SPACES;
         str3          <= SPACES;
         str4          <= SPACES;
      end else begin
         update <= 1'b0;
         case (state)
            IDLE: begin
               if (|s_axis_tvalid) begin
                  grant         <= next_grant;
                  s_axis_tready <= next_oh;
                  state         <= ACCEPT;
               end
            end
            ACCEPT: begin
               s_axis_tready <= '0;
               if (handshake) begin
                  src_id     <= grant;
                  last_grant <= grant;
                  hold_cnt   <= CNT_W'(HOLD_CYCLES - 1);
                  state      <= HOLD;
               end else begin
                  // Source withdrew its frame: nothing shown, pointer kept.
                  state <= IDLE;
               end
            end
            HOLD: begin
               if (hold_cnt == '0) begin
                  state <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // A new frame wins over blanking; a clear on that edge is deferred
         // one cycle so both content changes get their own update pulse.
         if (handshake) begin
            {str4, str3, str2, str1} <= grant_frame;
            update                   <= 1'b1;
            if (clear) begin
               clr_pend <= 1'b1;
            end
         end else if (clear || clr_pend) begin
            str1     <= SPACES;
            str2     <= SPACES;
            str3     <= SPACES;
            str4     <= SPACES;
            update   <= 1'b1;
            clr_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_oled_text_arbiter.sv
// tb_oled_text_arbiter
// Directed and randomized stimulus for oled_text_arbiter with a two-source
// instance (HOLD_CYCLES=4) and a three-source instance (HOLD_CYCLES=2).
// Expected grants come from a plain round-robin pick over request masks and
// expected display contents from the frames the bench itself offered.
module tb_oled_text_arbiter;

   localparam int           N2 = 2;
   localparam int           H2 = 4;
   localparam int           N3 = 3;
   localparam int           H3 = 2;
   localparam logic [127:0] SPACES = {16{8'h20}};

   // ---------------- clock / reset ----------------
   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- two-source instance ----------------
   logic [511:0]        f2 [N2];
   logic [N2*512-1:0]   td2;
   logic [N2-1:0]       tv2, tr2;
   logic                clr2, up2, busy2;
   logic [127:0]        s2_1, s2_2, s2_3, s2_4;
   logic [0:0]          id2;

   assign td2 = {f2[1], f2[0]};

   oled_text_arbiter #(.NUM_SRC(N2), .HOLD_CYCLES(H2)) dut (
      .clk(clk), .resetn(resetn),
      .s_axis_tdata(td2), .s_axis_tvalid(tv2), .s_axis_tready(tr2),
      .clear(clr2),
      .str1(s2_1), .str2(s2_2), .str3(s2_3), .str4(s2_4),
      .update(up2), .src_id(id2), .busy(busy2)
   );

   // ---------------- three-source instance ----------------
   logic [511:0]        f3 [N3];
   logic [N3*512-1:0]   td3;
   logic [N3-1:0]       tv3, tr3;
   logic                clr3, up3, busy3;
   logic [127:0]        s3_1, s3_2, s3_3, s3_4;
   logic [1:0]          id3;

   assign td3 = {f3[2], f3[1], f3[0]};

   oled_text_arbiter #(.NUM_SRC(N3), .HOLD_CYCLES(H3)) dut3 (
      .clk(clk), .resetn(resetn),
      .s_axis_tdata(td3), .s_axis_tvalid(tv3), .s_axis_tready(tr3),
      .clear(clr3),
      .str1(s3_1), .str2(s3_2), .str3(s3_3), .str4(s3_4),
      .update(up3), .src_id(id3), .busy(busy3)
   );

   // ---------------- reference model state ----------------
   int           checks   = 0;
   int           failures = 0;
   int           last2    = N2 - 1;
   int           last3    = N3 - 1;
   logic [511:0] disp2;
   logic [511:0] disp3;
   int           tc, uc, prev_tc;
   logic [N2-1:0] m2;
   logic [N3-1:0] m3;

   function automatic int rr_pick(input int mask, input int last, input int n);
      for (int k = 1; k <= n; k++) begin
         int c;
         c = (last + k) % n;
         if (mask[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [511:0] rnd_frame();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   // Offer mask on the two-source instance and check the resulting grant.
   task automatic grant2(input logic [N2-1:0] mask, input bit keep_valid, input bit clr_hs,
                         input int exp_lat, output int tr_cyc, output int upd_cyc);
      int exp_src, n;
      bit seen;
      exp_src = rr_pick(int'(mask), last2, N2);
      tv2  = mask;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         tick();
         n++;
         if (tr2 != '0) seen = 1'b1;
      end
      chk("rr2_tready_seen", 512'(seen), 512'(1));
      tr_cyc  = cyc;
      upd_cyc = cyc + 1;
      if (!seen) begin
         tv2 = '0;
         return;
      end
      if (exp_lat != 0) chk("rr2_latency", 512'(n), 512'(exp_lat));
      chk("rr2_tready_grant", 512'(tr2), 512'(1 << exp_src));
      if (clr_hs) clr2 = 1'b1;
      tick();
      disp2 = f2[exp_src];
      last2 = exp_src;
      chk("rr2_update", 512'(up2), 512'(1));
      chk("rr2_frame", {s2_4, s2_3, s2_2, s2_1}, disp2);
      chk("rr2_src_id", 512'(id2), 512'(exp_src));
      chk("rr2_tready_low", 512'(tr2), 512'(0));
      chk("rr2_busy", 512'(busy2), 512'(1));
      f2[exp_src] = rnd_frame();
      if (!keep_valid) tv2 = '0;
      if (clr_hs) begin
         // clear held for a second cycle merges into the deferred blanking
         tick();
         clr2  = 1'b0;
         disp2 = {4{SPACES}};
         chk("clr_hs_update", 512'(up2), 512'(1));
         chk("clr_hs_blank", {s2_4, s2_3, s2_2, s2_1}, disp2);
         tick();
         chk("clr_hs_single", 512'(up2), 512'(0));
      end
   endtask

   task automatic wait_idle2(input int upd_cyc);
      int n;
      n = 0;
      while (busy2 && n < 40) begin
         tick();
         n++;
      end
      chk("hold2_length", 512'(cyc - upd_cyc), 512'(H2));
   endtask

   // Full transaction on the three-source instance, including the hold.
   task automatic grant3(input logic [N3-1:0] mask);
      int exp_src, n, upd;
      bit seen;
      exp_src = rr_pick(int'(mask), last3, N3);
      tv3  = mask;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         tick();
         n++;
         if (tr3 != '0) seen = 1'b1;
      end
      chk("rr3_tready_seen", 512'(seen), 512'(1));
      if (!seen) begin
         tv3 = '0;
         return;
      end
      chk("rr3_tready_grant", 512'(tr3), 512'(1 << exp_src));
      tick();
      upd   = cyc;
      disp3 = f3[exp_src];
      last3 = exp_src;
      chk("rr3_update", 512'(up3), 512'(1));
      chk("rr3_frame", {s3_4, s3_3, s3_2, s3_1}, disp3);
      chk("rr3_src_id", 512'(id3), 512'(exp_src));
      tv3 = '0;
      f3[exp_src] = rnd_frame();
      n = 0;
      while (busy3 && n < 40) begin
         tick();
         n++;
      end
      chk("hold3_length", 512'(cyc - upd), 512'(H3));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit");
   end

   // ---------------- directed sequence ----------------
   initial begin
      for (int i = 0; i < N2; i++) f2[i] = rnd_frame();
      for (int i = 0; i < N3; i++) f3[i] = rnd_frame();
      tv2   = '0;
      tv3   = '0;
      clr2  = 1'b0;
      clr3  = 1'b0;
      disp2 = {4{SPACES}};
      disp3 = {4{SPACES}};

      // reset state
      tick();
      tick();
      chk("rst_str", {s2_4, s2_3, s2_2, s2_1}, disp2);
      chk("rst_update", 512'(up2), 512'(0));
      chk("rst_tready", 512'(tr2), 512'(0));
      chk("rst_busy", 512'(busy2), 512'(0));
      chk("rst_src_id", 512'(id2), 512'(0));
      chk("rst3_str", {s3_4, s3_3, s3_2, s3_1}, disp3);
      resetn = 1'b1;
      tick();
      chk("rst_busy_after_release", 512'(busy2), 512'(0));

      // both valid from reset, then kept valid: grants alternate 0,1,0,1
      grant2(2'b11, 1'b1, 1'b0, 1, tc, uc);
      prev_tc = tc;
      for (int g = 1; g < 4; g++) begin
         grant2(2'b11, (g < 3), 1'b0, 0, tc, uc);
         chk("rr2_spacing", 512'(tc - prev_tc), 512'(H2 + 2));
         prev_tc = tc;
      end
      wait_idle2(uc);

      // src0 alone, then src1 withdraws during its accept cycle
      grant2(2'b01, 1'b0, 1'b0, 1, tc, uc);
      wait_idle2(uc);
      tv2 = 2'b10;
      tick();
      chk("slip_tready", 512'(tr2), 512'(2'b10));
      tv2 = 2'b00;
      tick();
      chk("slip_no_update", 512'(up2), 512'(0));
      chk("slip_idle", 512'(busy2), 512'(0));
      chk("slip_display", {s2_4, s2_3, s2_2, s2_1}, disp2);
      grant2(2'b11, 1'b0, 1'b0, 1, tc, uc);
      wait_idle2(uc);

      // clear during hold
      m2 = N2'($urandom_range(1, 3));
      grant2(m2, 1'b0, 1'b0, 1, tc, uc);
      tick();
      clr2 = 1'b1;
      tick();
      clr2  = 1'b0;
      disp2 = {4{SPACES}};
      chk("clr_hold_update", 512'(up2), 512'(1));
      chk("clr_hold_blank", {s2_4, s2_3, s2_2, s2_1}, disp2);
      chk("clr_hold_src_id", 512'(id2), 512'(last2));
      chk("clr_hold_busy", 512'(busy2), 512'(1));
      wait_idle2(uc);

      // clear on the handshake edge
      m2 = N2'($urandom_range(1, 3));
      grant2(m2, 1'b0, 1'b1, 1, tc, uc);
      wait_idle2(uc);

      // randomized requests
      for (int r = 0; r < 6; r++) begin
         m2 = N2'($urandom_range(1, 3));
         grant2(m2, 1'b0, 1'b0, 1, tc, uc);
         wait_idle2(uc);
      end

      // clear while idle
      clr2 = 1'b1;
      tick();
      clr2  = 1'b0;
      disp2 = {4{SPACES}};
      chk("clr_idle_update", 512'(up2), 512'(1));
      chk("clr_idle_blank", {s2_4, s2_3, s2_2, s2_1}, disp2);
      tick();
      chk("clr_idle_single", 512'(up2), 512'(0));

      // reset in the middle of a hold with src0 shown
      grant2(2'b01, 1'b0, 1'b0, 1, tc, uc);
      tick();
      resetn = 1'b0;
      #1;
      last2 = N2 - 1;
      last3 = N3 - 1;
      disp2 = {4{SPACES}};
      disp3 = {4{SPACES}};
      chk("midrst_str", {s2_4, s2_3, s2_2, s2_1}, disp2);
      chk("midrst_update", 512'(up2), 512'(0));
      chk("midrst_src_id", 512'(id2), 512'(0));
      chk("midrst_tready", 512'(tr2), 512'(0));
      chk("midrst_busy", 512'(busy2), 512'(0));
      tick();
      resetn = 1'b1;
      tick();
      grant2(2'b11, 1'b0, 1'b0, 1, tc, uc);
      wait_idle2(uc);

      // three sources: lone src2, then a full tie wraps to src0
      grant3(3'b100);
      grant3(3'b111);
      for (int r = 0; r < 6; r++) begin
         m3 = N3'($urandom_range(1, 7));
         grant3(m3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
